sparc_mul_arb: RTL and testbench

SPARC_MUL_ARB -- requirements
Module: sparc_mul_arb

---
 rtl/sparc_mul_arb_pkg.sv | 17 +
 rtl/sparc_mul_arb_if.sv | 36 +++
 rtl/sparc_mul_trk.sv | 41 ++++
 rtl/sparc_mul_arb.sv | 73 +++++++
 tb/tb_sparc_mul_arb.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/sparc_mul_arb_pkg.sv
// sparc_mul_arb_pkg: shared latency default, tracker entry layout and grant encoding
package sparc_mul_arb_pkg;

    localparam int MUL_LAT_DEF = 5;

    typedef struct packed {
        logic vld;
        logic spu;
        logic acc;
    } trk_ent_t;

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_SPU = 1'b1
    } gnt_e;

endpackage

// File: rtl/sparc_mul_arb_if.sv
// sparc_mul_arb_if: requester-side requests and arbiter/datapath control outputs
interface sparc_mul_arb_if;

    logic ecl_mul_req_vld;
    logic spu_mul_req_vld;
    logic spu_mul_acc;
    logic spu_mul_x2;
    logic spu_mul_areg_shf;
    logic spu_mul_areg_rst;
    logic valid;
    logic spick;
    logic x2;
    logic acc_actc3;
    logic acc_reg_enb;
    logic acc_reg_rst;
    logic acc_reg_shf;
    logic mul_ecl_ack;
    logic mul_spu_ack;
    logic mul_exu_data_vld;
    logic mul_spu_data_vld;

    modport master (
        output ecl_mul_req_vld, spu_mul_req_vld, spu_mul_acc, spu_mul_x2,
               spu_mul_areg_shf, spu_mul_areg_rst,
        input  valid, spick, x2, acc_actc3, acc_reg_enb, acc_reg_rst, acc_reg_shf,
               mul_ecl_ack, mul_spu_ack, mul_exu_data_vld, mul_spu_data_vld
    );

    modport slave (
        input  ecl_mul_req_vld, spu_mul_req_vld, spu_mul_acc, spu_mul_x2,
               spu_mul_areg_shf, spu_mul_areg_rst,
        output valid, spick, x2, acc_actc3, acc_reg_enb, acc_reg_rst, acc_reg_shf,
               mul_ecl_ack, mul_spu_ack, mul_exu_data_vld, mul_spu_data_vld
    );

endinterface

// File: rtl/sparc_mul_trk.sv
// sparc_mul_trk: MUL_LAT-deep shift register following each issued op to its result cycle
module sparc_mul_trk
    import sparc_mul_arb_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic     rclk,
    input  logic     rst_l,
    input  logic     issue,
    input  logic     spu,
    input  logic     acc,
    output trk_ent_t out_ent,
    output logic     exu_busy,
    output logic     spu_busy,
    output logic     spu_any
);

    trk_ent_t [MUL_LAT-1:0] stg_q, stg_d;

    assign out_ent = stg_q[MUL_LAT-1];
    assign spu_any = spu_busy | (out_ent.vld & out_ent.spu);

    // shift in the issued op; busy covers all stages but the last, so a requester frees up in its result cycle
    always_comb begin
        stg_d[0] = '{vld: issue, spu: issue & spu, acc: issue & spu & acc};
        for (int k = 1; k < MUL_LAT; k++) stg_d[k] = stg_q[k-1];
        exu_busy = 1'b0;
        spu_busy = 1'b0;
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            exu_busy = exu_busy | (stg_q[k].vld & ~stg_q[k].spu);
            spu_busy = spu_busy | (stg_q[k].vld & stg_q[k].spu);
        end
    end

    // tracker state, discarded on reset
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) stg_q <= '0;
        else        stg_q <= stg_d;
    end

endmodule

// File: rtl/sparc_mul_arb.sv
// sparc_mul_arb: EXU/SPU multiplier arbiter with result tracking and ACCUM register control
module sparc_mul_arb
    import sparc_mul_arb_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic rclk,
    input  logic rst_l,
    sparc_mul_arb_if.slave bus
);

    trk_ent_t out_ent;
    logic     exu_busy, spu_busy, spu_any;
    gnt_e     last_q, last_d;
    logic     pend_q, pend_d, dly_q, dly_d;
    logic     ack_e, ack_s, spu_done, areg_rst, shf;

    sparc_mul_trk #(.MUL_LAT(MUL_LAT)) u_trk (
        .rclk     (rclk),
        .rst_l    (rst_l),
        .issue    (ack_e | ack_s),
        .spu      (ack_s),
        .acc      (bus.spu_mul_acc),
        .out_ent  (out_ent),
        .exu_busy (exu_busy),
        .spu_busy (spu_busy),
        .spu_any  (spu_any)
    );

    // grant eligible requesters; on a tie the side not granted last wins
    always_comb begin
        ack_e  = rst_l & bus.ecl_mul_req_vld & ~exu_busy
               & (~(bus.spu_mul_req_vld & ~spu_busy) | (last_q == GNT_SPU));
        ack_s  = rst_l & bus.spu_mul_req_vld & ~spu_busy & ~ack_e;
        last_d = ack_e ? GNT_EXU : ack_s ? GNT_SPU : last_q;
    end

    // ACCUM shift: immediate when no SPU op is outstanding, else deferred to the cycle after its result
    always_comb begin
        spu_done = out_ent.vld & out_ent.spu;
        areg_rst = rst_l & bus.spu_mul_areg_rst;
        shf      = rst_l & ~bus.spu_mul_areg_rst
                 & ((bus.spu_mul_areg_shf & ~spu_any & ~pend_q) | dly_q);
        pend_d   = ~areg_rst & ~dly_q & (pend_q | (bus.spu_mul_areg_shf & spu_any));
        dly_d    = ~areg_rst & spu_done & (pend_q | bus.spu_mul_areg_shf);
    end

    // arbitration history and deferred-shift state
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            last_q <= GNT_SPU;
            pend_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            pend_q <= pend_d;
            dly_q  <= dly_d;
        end
    end

    assign bus.valid            = ack_e | ack_s;
    assign bus.spick            = ack_s;
    assign bus.x2               = ack_s & bus.spu_mul_x2;
    assign bus.acc_actc3        = ack_s & bus.spu_mul_acc;
    assign bus.mul_ecl_ack      = ack_e;
    assign bus.mul_spu_ack      = ack_s;
    assign bus.mul_exu_data_vld = rst_l & out_ent.vld & ~out_ent.spu;
    assign bus.mul_spu_data_vld = rst_l & spu_done;
    assign bus.acc_reg_rst      = areg_rst;
    assign bus.acc_reg_shf      = shf;
    assign bus.acc_reg_enb      = rst_l & ((spu_done & out_ent.acc) | shf | areg_rst);

endmodule

// File: tb/tb_sparc_mul_arb.sv
// tb_sparc_mul_arb: directed and random stimulus checked against a due-cycle reference model
module tb_sparc_mul_arb;

    localparam int LAT = 5;

    logic rclk = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0, errors = 0, cyc = 0;
    int   exu_due = -1, spu_due = -1, shf_at = -1;
    bit   last_spu = 1'b1, spu_acc = 1'b0, m_ae, m_as;
    bit   er = 1'b0, sr = 1'b0, ra = 1'b0, rx = 1'b0;

    sparc_mul_arb_if bus ();

    sparc_mul_arb #(.MUL_LAT(LAT)) dut (
        .rclk  (rclk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    wire [10:0] obs = {bus.valid, bus.spick, bus.x2, bus.acc_actc3, bus.acc_reg_enb,
                       bus.acc_reg_rst, bus.acc_reg_shf, bus.mul_ecl_ack, bus.mul_spu_ack,
                       bus.mul_exu_data_vld, bus.mul_spu_data_vld};

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic drive(input bit e, s, a, x, sh, r);
        bus.ecl_mul_req_vld  = e;
        bus.spu_mul_req_vld  = s;
        bus.spu_mul_acc      = a;
        bus.spu_mul_x2       = x;
        bus.spu_mul_areg_shf = sh;
        bus.spu_mul_areg_rst = r;
    endtask

    task automatic model_reset();
        exu_due  = -1;
        spu_due  = -1;
        shf_at   = -1;
        last_spu = 1'b1;
    endtask

    // one clock cycle: compare at negedge, advance the model, return at posedge+1
    task automatic cycle();
        bit ge, gs, edv, sdv, infl, pend, now, xs, en, r, sh;
        @(negedge rclk);
        r    = bus.spu_mul_areg_rst;
        sh   = bus.spu_mul_areg_shf;
        ge   = bus.ecl_mul_req_vld && !(exu_due > cyc);
        gs   = bus.spu_mul_req_vld && !(spu_due > cyc);
        m_ae = ge && (!gs || last_spu);
        m_as = gs && !m_ae;
        edv  = exu_due == cyc;
        sdv  = spu_due == cyc;
        infl = spu_due >= cyc;
        pend = shf_at >= cyc;
        now  = sh && !pend && !infl;
        xs   = !r && (now || shf_at == cyc);
        en   = (sdv && spu_acc) || xs || r;
        chk($sformatf("cyc%0d", cyc), obs,
            {m_ae | m_as, m_as, m_as & bus.spu_mul_x2, m_as & bus.spu_mul_acc, en, r, xs,
             m_ae, m_as, edv, sdv});
        if (r) shf_at = -1;
        else if (sh && !pend && infl) shf_at = spu_due + 1;
        if (m_ae) begin
            exu_due  = cyc + LAT;
            last_spu = 1'b0;
        end
        if (m_as) begin
            spu_due  = cyc + LAT;
            spu_acc  = bus.spu_mul_acc;
            last_spu = 1'b1;
        end
        cyc++;
        @(posedge rclk);
        #1;
    endtask

    // asynchronous reset pulse starting mid-cycle, with every request asserted
    task automatic pulse_rst();
        rst_l = 1'b0;
        drive(1, 1, 1, 1, 1, 1);
        #1 chk("rst_async", obs, '0);
        @(posedge rclk);
        #1 chk("rst_hold", obs, '0);
        rst_l = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 1, 1, 1, 1, 1);
        #1 chk("por", obs, '0);
        @(posedge rclk);
        #1;
        rst_l = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        // lone EXU request
        drive(1, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); repeat (7) cycle();
        // simultaneous requests right after reset
        pulse_rst();
        drive(1, 1, 0, 0, 0, 0); cycle();
        drive(0, 1, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); repeat (7) cycle();
        // SPU accumulate with doubling
        drive(0, 1, 1, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); repeat (6) cycle();
        // shift requested while an SPU op is in flight
        drive(0, 1, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); repeat (5) cycle();
        // clear and shift together
        drive(0, 0, 0, 0, 1, 1); cycle();
        drive(0, 0, 0, 0, 0, 0); cycle();
        // reset two cycles after an SPU issue
        drive(0, 1, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0); repeat (2) cycle();
        pulse_rst();
        repeat (6) cycle();
        // random traffic, requests held until granted or occasionally withdrawn
        repeat (3000) begin
            if (er && $urandom_range(9) == 0) er = 1'b0;
            else if (!er && $urandom_range(9) < 4) er = 1'b1;
            if (sr && $urandom_range(9) == 0) sr = 1'b0;
            else if (!sr && $urandom_range(9) < 4) begin
                sr = 1'b1;
                ra = 1'($urandom_range(1));
                rx = 1'($urandom_range(1));
            end
            if ($urandom_range(199) == 0) pulse_rst();
            drive(er, sr, ra, rx, $urandom_range(6) == 0, $urandom_range(19) == 0);
            cycle();
            if (m_ae) er = 1'b0;
            if (m_as) sr = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
